gray_code_counter: RTL and testbench

- Parametrised binary/Gray up/down counter and the successor to the fixed 4-bit combinational binary-to-Gray converter.
- Holds a WIDTH-bit binary count and presents its registered Gray encoding, gray = bin ^ (bin >> 1).
- Supports synchronous load, enable, direction control and a terminal-count pulse.
- Used as a pointer/position source where single-bit-change outputs are required, e.g. async FIFO pointers and encoder emulation.

---
 rtl/gray_code_counter.sv | 106 ++++++++++
 tb/tb_gray_code_counter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/gray_code_counter.sv
// -----------------------------------------------------------------------------
// gray_code_counter
//
// Parametrised up/down binary counter with a registered Gray-code view.
// The binary count and its Gray encoding are loaded into registers on the same
// edge, so both outputs always describe the same position. There is no
// combinational path from any input to any output.
//
// Parameters:
//   WIDTH      counter/output width in bits (2..32)
//   RESET_VAL  binary value taken on reset (< 2**WIDTH)
//
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset (overrides load and en)
//   en        count enable, one step per cycle while high
//   up_dn     1 = increment, 0 = decrement
//   load      synchronous load strobe (beats en)
//   load_bin  binary value taken when load = 1
//   bin_out   registered binary count
//   gray_out  registered Gray encoding of bin_out
//   wrap      one-cycle pulse when a step crosses the max/0 boundary
//
// Build option:
//   GRAY_CNT_SATURATE_EN  when defined, the count stops at the boundary
//                         instead of wrapping, and wrap flags every enabled
//                         cycle whose step was blocked.
// -----------------------------------------------------------------------------
module gray_code_counter #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;

  function automatic logic [WIDTH-1:0] gray_enc(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // True when a step in direction dir from b would leave the 0..MAX range.
  function automatic logic at_boundary(input logic [WIDTH-1:0] b,
                                       input logic             dir);
    return dir ? (b == MAX_VAL) : (b == '0);
  endfunction

  function automatic logic [WIDTH-1:0] step_val(input logic [WIDTH-1:0] b,
                                                input logic             dir);
    return dir ? (b + WIDTH'(1)) : (b - WIDTH'(1));
  endfunction

  logic [WIDTH-1:0] bin_p0;
  logic [WIDTH-1:0] gray_p0;
  logic             wrap_p0;

  logic [WIDTH-1:0] bin_next;
  logic             wrap_next;
  logic             edge_hit;

  always_comb begin
    bin_next  = bin_p0;
    wrap_next = 1'b0;
    edge_hit  = at_boundary(bin_p0, up_dn);
    if (load) begin
      bin_next  = load_bin;
    end else if (en) begin
      wrap_next = edge_hit;
`ifdef GRAY_CNT_SATURATE_EN
      // A blocked step leaves the count (and so the Gray code) untouched.
      if (!edge_hit) begin
        bin_next = step_val(bin_p0, up_dn);
      end
`else
      // Modulo arithmetic: carry/borrow is dropped, wrap reports it.
      bin_next = step_val(bin_p0, up_dn);
`endif
    end
  end

  // ---- stage p0: output registers ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_p0  <= RESET_VAL;
      gray_p0 <= gray_enc(RESET_VAL);
      wrap_p0 <= 1'b0;
    end else begin
      bin_p0  <= bin_next;
      gray_p0 <= gray_enc(bin_next);
      wrap_p0 <= wrap_next;
    end
  end

  assign bin_out  = bin_p0;
  assign gray_out = gray_p0;
  assign wrap     = wrap_p0;

endmodule

// File: tb/tb_gray_code_counter.sv
module tb_gray_code_counter;

  localparam int W   = 4;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n, en, up_dn, load;
  logic [W-1:0] load_bin;
  logic [W-1:0] bin_a, gray_a, bin_b, gray_b;
  logic         wrap_a, wrap_b;

  always #5 clk = ~clk;

  gray_code_counter #(.WIDTH(W), .RESET_VAL(4'd0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
    .load_bin(load_bin), .bin_out(bin_a), .gray_out(gray_a), .wrap(wrap_a)
  );

  gray_code_counter #(.WIDTH(W), .RESET_VAL(4'd5)) dut5 (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
    .load_bin(load_bin), .bin_out(bin_b), .gray_out(gray_b), .wrap(wrap_b)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: integer positions and a reflected Gray table.
  int gtab [0:MAXV];
  int m_bin  [2];
  int m_wrap [2];
  int m_prev_gray;
  int m_moved;
  int rv     [2] = '{0, 5};

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_update(input int u);
    int nxt;
    if (!rst_n) begin
      m_bin[u] = rv[u]; m_wrap[u] = 0;
    end else if (load) begin
      m_bin[u] = int'(load_bin); m_wrap[u] = 0;
    end else if (en) begin
      nxt = up_dn ? m_bin[u] + 1 : m_bin[u] - 1;
      if (nxt > MAXV || nxt < 0) begin
        m_wrap[u] = 1;
`ifndef GRAY_CNT_SATURATE_EN
        m_bin[u] = (nxt + MAXV + 1) % (MAXV + 1);
`endif
      end else begin
        m_bin[u] = nxt; m_wrap[u] = 0;
      end
    end else begin
      m_wrap[u] = 0;
    end
  endtask

  // One clock: drive at negedge, model on posedge, sample 1 time unit later.
  task automatic step(input logic r, input logic e, input logic d,
                      input logic l, input logic [W-1:0] lb);
    int old_bin;
    @(negedge clk);
    rst_n = r; en = e; up_dn = d; load = l; load_bin = lb;
    @(posedge clk);
    old_bin     = m_bin[0];
    m_prev_gray = gtab[m_bin[0]];
    model_update(0);
    model_update(1);
    m_moved = (old_bin != m_bin[0]) ? 1 : 0;
    #1;
    check("bin_a",  32'(bin_a),  32'(m_bin[0]));
    check("gray_a", 32'(gray_a), 32'(gtab[m_bin[0]]));
    check("wrap_a", 32'(wrap_a), 32'(m_wrap[0]));
    check("bin_b",  32'(bin_b),  32'(m_bin[1]));
    check("gray_b", 32'(gray_b), 32'(gtab[m_bin[1]]));
    check("wrap_b", 32'(wrap_b), 32'(m_wrap[1]));
    // During plain counting the Gray code must move by exactly one bit.
    if (r && !l && e)
      check("gray_1bit", 32'($countones(gray_a ^ W'(m_prev_gray))), 32'(m_moved));
  endtask

  logic [W-1:0] sweep [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                               4'b0110, 4'b0111, 4'b0101, 4'b0100,
                               4'b1100, 4'b1101, 4'b1111, 4'b1110,
                               4'b1010, 4'b1011, 4'b1001, 4'b1000};

  initial begin
    gtab[0] = 0;
    for (int k = 0; k < W; k++) begin
      int n;
      n = 1 << k;
      for (int i = 0; i < n; i++) gtab[n + i] = gtab[n - 1 - i] | n;
    end
    m_bin[0] = 0; m_bin[1] = 5; m_wrap[0] = 0; m_wrap[1] = 0;
    rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_bin = '0;

    // Reset for two cycles with en high, then first count.
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    check("rst_bin",  32'(bin_a),  32'd0);
    check("rst_gray", 32'(gray_a), 32'd0);
    check("rst_wrap", 32'(wrap_a), 32'd0);
    check("rst5_gray", 32'(gray_b), 32'b0111);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    check("first_bin",  32'(bin_a),  32'd1);
    check("first_gray", 32'(gray_a), 32'b0001);

    // Full up sweep from 0.
    step(1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
    check("sweep_gray0", 32'(gray_a), 32'(sweep[0]));
    for (int i = 1; i < 16; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
      check("sweep_gray", 32'(gray_a), 32'(sweep[i]));
      check("sweep_nowrap", 32'(wrap_a), 32'd0);
    end
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    check("sweep_wrap", 32'(wrap_a), 32'd1);
`ifdef GRAY_CNT_SATURATE_EN
    check("sweep_end_gray", 32'(gray_a), 32'b1000);
`else
    check("sweep_end_gray", 32'(gray_a), 32'b0000);
`endif

    // Down across zero.
    step(1'b1, 1'b0, 1'b0, 1'b1, 4'd1);
    check("dn_gray1", 32'(gray_a), 32'b0001);
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    check("dn_gray0", 32'(gray_a), 32'b0000);
    check("dn_wrap0", 32'(wrap_a), 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    check("dn_wrap", 32'(wrap_a), 32'd1);
`ifndef GRAY_CNT_SATURATE_EN
    check("dn_bin15", 32'(bin_a), 32'd15);
    check("dn_gray15", 32'(gray_a), 32'b1000);
`endif

    // Load beats enable, then hold.
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'd10);
    check("ld_bin",  32'(bin_a),  32'd10);
    check("ld_gray", 32'(gray_a), 32'b1111);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0, 4'd3);
      check("hold_bin",  32'(bin_a),  32'd10);
      check("hold_wrap", 32'(wrap_a), 32'd0);
    end

    // Reset mid-count with load asserted.
    step(1'b1, 1'b0, 1'b1, 1'b1, 4'd6);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    check("pre_rst_bin", 32'(bin_a), 32'd7);
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'd12);
    check("mid_rst_bin",   32'(bin_a),  32'd0);
    check("mid_rst5_bin",  32'(bin_b),  32'd5);
    check("mid_rst5_gray", 32'(gray_b), 32'b0111);
    check("mid_rst_wrap",  32'(wrap_a), 32'd0);

`ifdef GRAY_CNT_SATURATE_EN
    step(1'b1, 1'b0, 1'b1, 1'b1, 4'd13);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    check("sat_reach", 32'(bin_a), 32'd15);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
      check("sat_bin",  32'(bin_a),  32'd15);
      check("sat_gray", 32'(gray_a), 32'b1000);
      check("sat_wrap", 32'(wrap_a), 32'd1);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    check("sat_back_bin",  32'(bin_a),  32'd14);
    check("sat_back_wrap", 32'(wrap_a), 32'd0);
`endif

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic r, e, d, l;
      r = ($urandom_range(0, 31) != 0);
      l = ($urandom_range(0, 15) == 0);
      e = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 7) < 5) ? 1'b1 : 1'b0;
      step(r, e, d, l, W'($urandom_range(0, MAXV)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
